uart_word_scheduler: RTL and testbench

- Round-robin scheduler that shares one hex-word UART transmitter among NUM_CH correlator channels.
- Accepts a RESOLUTION-bit word from each requester using a valid/ready handshake.
- Forwards each accepted word to the word transmitter and waits for its done pulse.
- Guards every transfer with a timeout, counts completed words, and sits between the correlator channel outputs and the serial word transmitter.

---
 rtl/uart_word_scheduler.sv | 155 +++++++++++++++
 tb/tb_uart_word_scheduler.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_scheduler.sv
// uart_word_scheduler: round-robin arbiter that hands one RESOLUTION-bit word
// at a time from NUM_CH requesters to a shared word transmitter, waits for its
// done pulse under a timeout, and counts completed words.
module uart_word_scheduler #(
   parameter int NUM_CH     = 4,
   parameter int CH_BITS    = 2,
   parameter int RESOLUTION = 32,
   parameter int TIMEOUT    = 1000000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_CH-1:0]            req_valid,
   input  logic [NUM_CH*RESOLUTION-1:0] req_data,
   output logic [NUM_CH-1:0]            req_ready,
   input  logic [NUM_CH-1:0]            chan_mask,
   output logic [RESOLUTION-1:0]        word_data,
   output logic [CH_BITS-1:0]           word_chan,
   output logic                         word_start,
   input  logic                         word_busy,
   input  logic                         word_done,
   output logic                         active,
   output logic                         timeout_err,
   input  logic                         err_clear,
   output logic [15:0]                  words_sent
);

   localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

   state_t                state, state_nxt;
   logic [CH_BITS-1:0]    last_grant, last_grant_nxt;
   logic [TIMER_W-1:0]    timer, timer_nxt;
   logic [NUM_CH-1:0]     eligible;
   logic                  grant_found;
   logic [CH_BITS-1:0]    grant_idx;
   logic [RESOLUTION-1:0] grant_word;
   logic [NUM_CH-1:0]     req_ready_nxt;
   logic                  word_start_nxt;
   logic [RESOLUTION-1:0] word_data_nxt;
   logic [CH_BITS-1:0]    word_chan_nxt;
   logic                  err_set;
   logic                  done_inc;

   assign eligible = req_valid & chan_mask;
   assign active   = (state != IDLE);

   // Round-robin search starting one past the previous grant, wrapping modulo NUM_CH
   always_comb begin
      int                 cand;
      logic [CH_BITS-1:0] cidx;
      grant_found = 1'b0;
      grant_idx   = '0;
      grant_word  = '0;
      cand        = 0;
      cidx        = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = (int'(last_grant) + k) % NUM_CH;
         cidx = CH_BITS'(cand);
         if (!grant_found && eligible[cidx]) begin
            grant_found = 1'b1;
            grant_idx   = cidx;
            grant_word  = RESOLUTION'(req_data >> (cand * RESOLUTION));
         end
      end
   end

   // Next-state and next-output logic; data/channel hold their value unless granted
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      timer_nxt      = timer;
      req_ready_nxt  = '0;
      word_start_nxt = 1'b0;
      word_data_nxt  = word_data;
      word_chan_nxt  = word_chan;
      err_set        = 1'b0;
      done_inc       = 1'b0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               word_data_nxt  = grant_word;
               word_chan_nxt  = grant_idx;
               req_ready_nxt  = NUM_CH'(1) << grant_idx;
               last_grant_nxt = grant_idx;
               state_nxt      = START;
            end
         end
         START: begin
            // Never start the transmitter while it reports busy
            if (!word_busy) begin
               word_start_nxt = 1'b1;
               timer_nxt      = '0;
               state_nxt      = WAIT;
            end
         end
         WAIT: begin
            // A done arriving on the final timer cycle still counts as success
            if (word_done) begin
               done_inc  = 1'b1;
               state_nxt = IDLE;
            end else if (timer == TIMER_LAST) begin
               err_set   = 1'b1;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer + TIMER_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register plus registered handshake/datapath outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= CH_BITS'(NUM_CH - 1);
         timer      <= '0;
         req_ready  <= '0;
         word_start <= 1'b0;
         word_data  <= '0;
         word_chan  <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         timer      <= timer_nxt;
         req_ready  <= req_ready_nxt;
         word_start <= word_start_nxt;
         word_data  <= word_data_nxt;
         word_chan  <= word_chan_nxt;
      end
   end

   // Sticky timeout flag; a new timeout outranks a simultaneous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         timeout_err <= 1'b0;
      end else if (err_set) begin
         timeout_err <= 1'b1;
      end else if (err_clear) begin
         timeout_err <= 1'b0;
      end
   end

   // Completed-word counter, wraps naturally at 16 bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         words_sent <= '0;
      end else if (done_inc) begin
         words_sent <= words_sent + 16'd1;
      end
   end

endmodule

// File: tb/tb_uart_word_scheduler.sv
// tb_uart_word_scheduler: scenario tasks plus a randomized run, checked against
// a transaction-level model (rotating-priority winner, outstanding-transfer age,
// expected word count and error flag) maintained in tick().
`timescale 1ns/1ps
module tb_uart_word_scheduler;

   localparam int NUM_CH  = 4;
   localparam int CH_BITS = 2;
   localparam int RES     = 32;
   localparam int TO      = 50;

   logic                  clk = 1'b0;
   logic                  reset = 1'b1;
   logic [NUM_CH-1:0]     req_valid = '0;
   logic [NUM_CH*RES-1:0] req_data = '0;
   logic [NUM_CH-1:0]     req_ready;
   logic [NUM_CH-1:0]     chan_mask = '1;
   logic [RES-1:0]        word_data;
   logic [CH_BITS-1:0]    word_chan;
   logic                  word_start;
   logic                  word_busy = 1'b0;
   logic                  word_done = 1'b0;
   logic                  active;
   logic                  timeout_err;
   logic                  err_clear = 1'b0;
   logic [15:0]           words_sent;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [15:0] exp_words;
   logic        exp_err;
   bit          outstanding;
   int          age;
   int          xcnt;
   bit          xmit_auto;
   int          xmit_delay;
   int          exp_last;
   int          pred;
   logic        samp_busy;

   uart_word_scheduler #(
      .NUM_CH(NUM_CH), .CH_BITS(CH_BITS), .RESOLUTION(RES), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .chan_mask(chan_mask), .word_data(word_data),
      .word_chan(word_chan), .word_start(word_start), .word_busy(word_busy),
      .word_done(word_done), .active(active), .timeout_err(timeout_err),
      .err_clear(err_clear), .words_sent(words_sent)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   function automatic int next_winner(logic [NUM_CH-1:0] e, int last);
      for (int k = 1; k <= NUM_CH; k++) begin
         if (e[(last + k) % NUM_CH]) return (last + k) % NUM_CH;
      end
      return -1;
   endfunction

   function automatic int onehot_idx(logic [NUM_CH-1:0] r);
      int idx;
      idx = -1;
      if ($onehot(r)) begin
         for (int i = 0; i < NUM_CH; i++) if (r[i]) idx = i;
      end
      return idx;
   endfunction

   function automatic logic [RES-1:0] chan_word(int c);
      return req_data[c*RES +: RES];
   endfunction

   task automatic set_word(int c, logic [RES-1:0] v);
      req_data[c*RES +: RES] = v;
   endtask

   task automatic model_clear();
      exp_words   = '0;
      exp_err     = 1'b0;
      outstanding = 0;
      age         = 0;
      xcnt        = 0;
      exp_last    = NUM_CH - 1;
      pred        = -1;
      word_done   = 1'b0;
   endtask

   // One clock: advance the model using the inputs the DUT sampled at this edge
   task automatic tick();
      logic [NUM_CH-1:0] elig;
      logic sd, sc, sb;
      bit   set_err;
      elig = req_valid & chan_mask;
      sd = word_done;
      sc = err_clear;
      sb = word_busy;
      @(posedge clk);
      #1;
      samp_busy = sb;
      if (req_ready != '0) begin
         pred = next_winner(elig, exp_last);
         if (pred >= 0) exp_last = pred;
      end
      set_err = 0;
      if (outstanding) begin
         age++;
         if (sd) begin
            exp_words   = exp_words + 16'd1;
            outstanding = 0;
         end else if (age == TO) begin
            set_err     = 1;
            outstanding = 0;
         end
      end
      if (set_err) exp_err = 1'b1;
      else if (sc) exp_err = 1'b0;
      if (word_start === 1'b1) begin
         outstanding = 1;
         age = 0;
      end
      word_done = 1'b0;
      if (xcnt > 0) begin
         xcnt--;
         if (xcnt == 0) word_done = 1'b1;
      end
      if (word_start === 1'b1 && xmit_auto) xcnt = xmit_delay;
   endtask

   task automatic apply_reset();
      reset      = 1'b1;
      req_valid  = '0;
      chan_mask  = '1;
      word_busy  = 1'b0;
      err_clear  = 1'b0;
      xmit_auto  = 1;
      xmit_delay = 20;
      model_clear();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_grant(input int budget, output int idx);
      idx = -2;
      for (int n = 0; n < budget; n++) begin
         tick();
         if (req_ready != '0) begin
            idx = onehot_idx(req_ready);
            return;
         end
      end
   endtask

   task automatic wait_start(input int budget, output bit ok);
      ok = 0;
      for (int n = 0; n < budget; n++) begin
         tick();
         if (word_start === 1'b1) begin
            ok = 1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      int g;
      bit ok;
      reset = 1'b1;
      xmit_auto = 1;
      xmit_delay = 5;
      model_clear();
      tick();
      tick();
      checks++;
      if ({req_ready, word_start, active, timeout_err, words_sent, word_data, word_chan} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b start=%b active=%b err=%b sent=%0d data=%h chan=%0d, required all 0",
                  req_ready, word_start, active, timeout_err, words_sent, word_data, word_chan);
      end
      reset = 1'b0;
      set_word(2, 32'($urandom));
      req_valid = 4'b0100;
      wait_grant(10, g);
      checks++;
      if (g !== 2) begin
         errors++;
         $display("FAIL reset_first_ch2: granted %0d, required 2", g);
      end
      for (int n = 0; n < 40 && exp_words == 0; n++) tick();
      checks++;
      if (words_sent !== 16'd1) begin
         errors++;
         $display("FAIL reset_prefill_count: words_sent %0d, required 1", words_sent);
      end
      xmit_auto = 0;
      wait_start(10, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL reset_regrant_start: word_start %b, required 1 within 10 cycles", word_start);
      end
      // DUT is now in WAIT with word_start high: reset must clear everything at once
      reset = 1'b1;
      #1;
      checks++;
      if ({word_start, req_ready, active, words_sent, timeout_err} !== '0) begin
         errors++;
         $display("FAIL reset_async: start=%b ready=%b active=%b sent=%0d err=%b, required all 0",
                  word_start, req_ready, active, words_sent, timeout_err);
      end
      model_clear();
      req_valid = 4'b1111;
      tick();
      reset = 1'b0;
      wait_grant(10, g);
      checks++;
      if (g !== 0 || g !== pred) begin
         errors++;
         $display("FAIL reset_then_ch0: granted %0d, required 0 (model %0d)", g, pred);
      end
   endtask

   task automatic test_round_robin();
      int g;
      int seq[5] = '{0, 1, 2, 3, 0};
      logic [RES-1:0] d;
      apply_reset();
      for (int c = 0; c < NUM_CH; c++) set_word(c, 32'h11111111 * 32'(c + 1));
      xmit_delay = 20;
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_grant(60, g);
         d = 32'h11111111 * 32'(seq[k] + 1);
         checks++;
         if (g !== seq[k] || g !== pred) begin
            errors++;
            $display("FAIL rr_order[%0d]: granted %0d ready=%b, required %0d (model %0d)", k, g, req_ready, seq[k], pred);
         end
         checks++;
         if (word_data !== d || word_chan !== CH_BITS'(seq[k])) begin
            errors++;
            $display("FAIL rr_data[%0d]: data %h chan %0d, required %h chan %0d", k, word_data, word_chan, d, seq[k]);
         end
         if (k == 4) begin
            checks++;
            if (words_sent !== 16'd4) begin
               errors++;
               $display("FAIL rr_count: words_sent %0d, required 4", words_sent);
            end
         end
         tick();
         checks++;
         if (req_ready !== '0) begin
            errors++;
            $display("FAIL rr_pulse[%0d]: ready %b one cycle after grant, required 0000", k, req_ready);
         end
      end
   endtask

   task automatic test_mask();
      int g;
      apply_reset();
      for (int c = 0; c < NUM_CH; c++) set_word(c, 32'($urandom));
      chan_mask = 4'b1010;
      req_valid = 4'b1111;
      xmit_delay = $urandom_range(3, 10);
      for (int k = 0; k < 6; k++) begin
         wait_grant(40, g);
         xmit_delay = $urandom_range(3, 10);
         checks++;
         if (g !== ((k % 2 == 0) ? 1 : 3) || (req_ready & 4'b0101) !== 4'b0000) begin
            errors++;
            $display("FAIL mask_grant[%0d]: granted %0d ready=%b, required %0d", k, g, req_ready, (k % 2 == 0) ? 1 : 3);
         end
         checks++;
         if (word_data !== chan_word(g < 0 ? 0 : g)) begin
            errors++;
            $display("FAIL mask_data[%0d]: data %h, required %h", k, word_data, chan_word(g < 0 ? 0 : g));
         end
      end
   endtask

   task automatic test_busy();
      int g;
      logic [RES-1:0] d;
      apply_reset();
      d = 32'($urandom);
      set_word(1, d);
      word_busy = 1'b1;
      req_valid = 4'b0010;
      wait_grant(10, g);
      req_valid = '0;
      checks++;
      if (g !== 1) begin
         errors++;
         $display("FAIL busy_grant: granted %0d, required 1", g);
      end
      for (int n = 0; n < 10; n++) begin
         tick();
         checks++;
         if (word_start !== 1'b0 || word_data !== d || active !== 1'b1) begin
            errors++;
            $display("FAIL busy_hold[%0d]: start %b data %h active %b, required 0 %h 1", n, word_start, word_data, active, d);
         end
      end
      word_busy = 1'b0;
      tick();
      checks++;
      if (word_start !== 1'b1 || word_data !== d) begin
         errors++;
         $display("FAIL busy_release: start %b data %h, required 1 %h", word_start, word_data, d);
      end
      tick();
      checks++;
      if (word_start !== 1'b0) begin
         errors++;
         $display("FAIL busy_start_pulse: start %b, required 0", word_start);
      end
      for (int n = 0; n < 40 && exp_words == 0; n++) tick();
      checks++;
      if (words_sent !== 16'd1 || words_sent !== exp_words) begin
         errors++;
         $display("FAIL busy_done_count: words_sent %0d, required 1", words_sent);
      end
   endtask

   task automatic test_timeout();
      int g;
      bit ok;
      apply_reset();
      xmit_auto = 0;
      set_word(0, 32'($urandom));
      req_valid = 4'b0001;
      wait_grant(10, g);
      req_valid = '0;
      wait_start(5, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL to_start: word_start %b, required 1 within 5 cycles", word_start);
      end
      repeat (TO - 1) tick();
      checks++;
      if (timeout_err !== 1'b0 || active !== 1'b1) begin
         errors++;
         $display("FAIL to_early: err %b active %b at 49 cycles, required 0 1", timeout_err, active);
      end
      tick();
      checks++;
      if (timeout_err !== 1'b1 || active !== 1'b0 || words_sent !== 16'd0 || timeout_err !== exp_err) begin
         errors++;
         $display("FAIL to_expire: err %b active %b sent %0d at 50 cycles, required 1 0 0", timeout_err, active, words_sent);
      end
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL to_clear: err %b, required 0", timeout_err);
      end
      req_valid = 4'b0001;
      wait_grant(10, g);
      req_valid = '0;
      wait_start(5, ok);
      repeat (TO - 1) tick();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      checks++;
      if (timeout_err !== 1'b1 || timeout_err !== exp_err) begin
         errors++;
         $display("FAIL to_set_beats_clear: err %b, required 1", timeout_err);
      end
      tick();
      checks++;
      if (timeout_err !== 1'b1 || words_sent !== 16'd0) begin
         errors++;
         $display("FAIL to_sticky: err %b sent %0d, required 1 0", timeout_err, words_sent);
      end
   endtask

   task automatic test_collision();
      int g;
      bit ok;
      apply_reset();
      xmit_auto = 0;
      set_word(3, 32'($urandom));
      req_valid = 4'b1000;
      wait_grant(10, g);
      req_valid = '0;
      wait_start(5, ok);
      repeat (TO - 1) tick();
      word_done = 1'b1;
      tick();
      checks++;
      if (timeout_err !== 1'b0 || words_sent !== 16'd1 || active !== 1'b0 || words_sent !== exp_words) begin
         errors++;
         $display("FAIL coll_done_wins: err %b sent %0d active %b, required 0 1 0", timeout_err, words_sent, active);
      end
      repeat (3) tick();
      word_done = 1'b1;
      tick();
      tick();
      checks++;
      if (words_sent !== 16'd1 || active !== 1'b0) begin
         errors++;
         $display("FAIL coll_stray_done: sent %0d active %b, required 1 0", words_sent, active);
      end
   endtask

   task automatic test_random();
      int g;
      apply_reset();
      xmit_delay = $urandom_range(1, 30);
      for (int n = 0; n < 2000; n++) begin
         chan_mask = 4'($urandom);
         word_busy = ($urandom_range(0, 3) == 0);
         for (int c = 0; c < NUM_CH; c++) begin
            if (!req_valid[c] && $urandom_range(0, 3) == 0) begin
               set_word(c, 32'($urandom));
               req_valid[c] = 1'b1;
            end
         end
         tick();
         if (word_start === 1'b1) begin
            checks++;
            if (samp_busy !== 1'b0) begin
               errors++;
               $display("FAIL rnd_busy_start[%0d]: word_start %b while busy %b, required start 0", n, word_start, samp_busy);
            end
         end
         if (req_ready !== '0) begin
            g = onehot_idx(req_ready);
            checks++;
            if (g !== pred || g < 0) begin
               errors++;
               $display("FAIL rnd_grant[%0d]: ready %b, required channel %0d", n, req_ready, pred);
            end else if (word_data !== chan_word(g) || word_chan !== CH_BITS'(g)) begin
               errors++;
               $display("FAIL rnd_grant_data[%0d]: data %h chan %0d, required %h chan %0d", n, word_data, word_chan, chan_word(g), g);
            end
            xmit_delay = $urandom_range(1, 30);
            if (g >= 0) begin
               if ($urandom_range(0, 1) == 0) req_valid[g] = 1'b0;
               else set_word(g, 32'($urandom));
            end
         end
         checks++;
         if (words_sent !== exp_words || timeout_err !== exp_err) begin
            errors++;
            $display("FAIL rnd_state[%0d]: sent %0d err %b, required %0d %b", n, words_sent, timeout_err, exp_words, exp_err);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_mask();
      test_busy();
      test_timeout();
      test_collision();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
